// File: rtl/adc_dual_serial_rx_pkg.sv
// Shared constants and state encoding for the dual-channel serial ADC reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_dual_serial_rx_pkg;

  // Sample width delivered by the converter on each data line.
  localparam int NBITS = 14;

  // Default timing: clk cycles per SCK half-period, and CS-high gap after DONE.
  localparam int CLK_DIV_DEF  = 4;
  localparam int CONV_GAP_DEF = 8;

  // Bit counter width and reload value (MSB index).
  localparam int BCW = $clog2(NBITS);
  localparam logic [BCW-1:0] BIT_MSB = BCW'(NBITS - 1);

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // True while the converter is selected (CS low) and SCK is being generated.
  function automatic logic is_active(input state_e s);
    return (s == ST_SETUP) || (s == ST_SHIFT);
  endfunction

endpackage

// File: rtl/adc_sck_tick.sv
// SCK half-period timer: CLK_DIV down-counter with a tick on the last cycle of each half.
// Latency: tick is combinational from the counter; phase toggles on the edge after a tick.
// Backpressure: none; held in reload (phase high) whenever en_i is low.
module adc_sck_tick
  import adc_dual_serial_rx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o,
  output logic phase_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  // Count down each half-period; reload and flip the phase when it expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b1;
    end else if (!en_i) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b1;
    end else if (cnt_q == '0) begin
      cnt_q   <= RELOAD;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  assign tick_o  = en_i && (cnt_q == '0);
  assign phase_o = phase_q;

endmodule

// File: rtl/adc_dual_serial_rx.sv
// Dual-channel serial ADC reader: drives CS/SCK/RD_DONE, deserialises DOUTA/DOUTB to 14-bit words.
// Latency: samples valid one cycle after the last SCK high half ends (CS rises with sample_valid).
// Backpressure: none; sample_valid is a single-cycle strobe, words hold until the next frame.
module adc_dual_serial_rx
  import adc_dual_serial_rx_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int CONV_GAP = CONV_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             DOUTA,
  input  logic             DOUTB,
  output logic             CS,
  output logic             SCK,
  output logic             RD_DONE,
  output logic [NBITS-1:0] sample_a,
  output logic [NBITS-1:0] sample_b,
  output logic             sample_valid
);

  localparam int GW = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(CONV_GAP - 1);

  state_e state_q, state_d;

  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             last_q, last_d;
  logic [NBITS-1:0] shift_a_q, shift_a_d;
  logic [NBITS-1:0] shift_b_q, shift_b_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             rd_done_q, rd_done_d;
  logic [NBITS-1:0] sample_a_q, sample_a_d;
  logic [NBITS-1:0] sample_b_q, sample_b_d;
  logic             valid_q, valid_d;

  logic tick;
  logic phase;
  logic capture;
  logic hi_end;

  adc_sck_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_tick (
    .clk     (clk),
    .rst     (rst),
    .en_i    (is_active(state_q)),
    .tick_o  (tick),
    .phase_o (phase)
  );

  // End of a low half in SHIFT is the SCK rising edge: data has settled for CLK_DIV cycles.
  assign capture = (state_q == ST_SHIFT) && tick && !phase;
  assign hi_end  = (state_q == ST_SHIFT) && tick &&  phase;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; en only matters in IDLE and at the end of GAP, so frames never abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (hi_end && last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_GAP;
      ST_GAP:   if (gap_q == '0) state_d = en ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: shift registers, bit counter and gap timer.
  always_comb begin
    bitcnt_d  = bitcnt_q;
    last_d    = last_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    gap_d     = gap_q;

    if (capture) begin
      shift_a_d = {shift_a_q[NBITS-2:0], DOUTA};
      shift_b_d = {shift_b_q[NBITS-2:0], DOUTB};
      // Counter sits at 0 for the final bit; last_q marks that all bits are in.
      if (bitcnt_q == '0) begin
        last_d = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q - 1'b1;
      end
    end

    if (state_q == ST_DONE) begin
      bitcnt_d = BIT_MSB;
      last_d   = 1'b0;
      gap_d    = GAP_RELOAD;
    end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q  <= BIT_MSB;
      last_q    <= 1'b0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      gap_q     <= '0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      last_q    <= last_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      gap_q     <= gap_d;
    end
  end

  // Output decode from the next state so every pin is a flop aligned with the state it reflects.
  always_comb begin
    cs_d       = !is_active(state_d);
    // In SHIFT the pin follows the phase the timer will hold next cycle.
    sck_d      = (state_d == ST_SHIFT) ? (tick ? ~phase : phase) : 1'b1;
    rd_done_d  = rd_done_q;
    sample_a_d = sample_a_q;
    sample_b_d = sample_b_q;
    valid_d    = 1'b0;

    if (state_d == ST_DONE) begin
      rd_done_d  = 1'b1;
      valid_d    = 1'b1;
      sample_a_d = shift_a_q;
      sample_b_d = shift_b_q;
    end else if (state_d == ST_SETUP) begin
      // RD_DONE stays up through GAP/IDLE and drops when CS falls.
      rd_done_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q       <= 1'b1;
      sck_q      <= 1'b1;
      rd_done_q  <= 1'b0;
      sample_a_q <= '0;
      sample_b_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      rd_done_q  <= rd_done_d;
      sample_a_q <= sample_a_d;
      sample_b_q <= sample_b_d;
      valid_q    <= valid_d;
    end
  end

  assign CS           = cs_q;
  assign SCK          = sck_q;
  assign RD_DONE      = rd_done_q;
  assign sample_a     = sample_a_q;
  assign sample_b     = sample_b_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_dual_serial_rx.sv
// Directed bench for adc_dual_serial_rx: default-timing instance plus a CLK_DIV=2/CONV_GAP=1 instance.
// Each instance has a serial converter model that presents the next bit on every SCK falling edge.
// Expected words, periods and CS-low widths are hand-computed constants.
module tb_adc_dual_serial_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance (CLK_DIV=4, CONV_GAP=8) ----------------
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        douta = 1'b0, doutb = 1'b0;
  logic        cs, sck, rd_done, svalid;
  logic [13:0] sa, sb;

  adc_dual_serial_rx dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .DOUTA        (douta),
    .DOUTB        (doutb),
    .CS           (cs),
    .SCK          (sck),
    .RD_DONE      (rd_done),
    .sample_a     (sa),
    .sample_b     (sb),
    .sample_valid (svalid)
  );

  // ---------------- fast instance (CLK_DIV=2, CONV_GAP=1) ----------------
  logic        rst2 = 1'b1;
  logic        en2  = 1'b0;
  logic        douta2 = 1'b0, doutb2 = 1'b0;
  logic        cs2, sck2, rd_done2, svalid2;
  logic [13:0] sa2, sb2;

  adc_dual_serial_rx #(
    .CLK_DIV  (2),
    .CONV_GAP (1)
  ) dut2 (
    .clk          (clk),
    .rst          (rst2),
    .en           (en2),
    .DOUTA        (douta2),
    .DOUTB        (doutb2),
    .CS           (cs2),
    .SCK          (sck2),
    .RD_DONE      (rd_done2),
    .sample_a     (sa2),
    .sample_b     (sb2),
    .sample_valid (svalid2)
  );

  // Words the converter model returns, one slot per CS falling edge.
  logic [13:0] fa [7] = '{14'h2A5B, 14'h0000, 14'h3FFF, 14'h2AAA, 14'h0C3A, 14'h1111, 14'h1ABC};
  logic [13:0] fb [7] = '{14'h1234, 14'h3FFF, 14'h0000, 14'h1555, 14'h3001, 14'h2222, 14'h0DEF};
  logic [13:0] w2a [14];
  logic [13:0] w2b [14];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Converter model, default instance: load a word at CS fall (SCK high), shift out on SCK fall.
  int          m_slot = 0;
  int          m_bit  = 14;
  logic [13:0] cur_a = '0, cur_b = '0;
  always @(negedge cs or negedge sck) begin
    if (sck) begin
      if (m_slot < 7) begin
        cur_a = fa[m_slot];
        cur_b = fb[m_slot];
      end
      m_slot++;
      m_bit = 14;
    end else if (!cs && m_bit > 0) begin
      m_bit--;
      douta = cur_a[m_bit];
      doutb = cur_b[m_bit];
    end
  end

  // Converter model, fast instance.
  int          m2_slot = 0;
  int          m2_bit  = 14;
  logic [13:0] cur2_a = '0, cur2_b = '0;
  always @(negedge cs2 or negedge sck2) begin
    if (sck2) begin
      if (m2_slot < 14) begin
        cur2_a = w2a[m2_slot];
        cur2_b = w2b[m2_slot];
      end
      m2_slot++;
      m2_bit = 14;
    end else if (!cs2 && m2_bit > 0) begin
      m2_bit--;
      douta2 = cur2_a[m2_bit];
      doutb2 = cur2_b[m2_bit];
    end
  end

  // Monitors sample on the falling clock edge.
  int          cyc = 0;
  int          cs_len = 0, cs2_len = 0;
  int          vc_q[$], cl_q[$], vc2_q[$];
  logic [13:0] va_q[$], vb_q[$], va2_q[$], vb2_q[$];
  always @(negedge clk) begin
    cyc++;
    if (svalid === 1'b1) begin
      vc_q.push_back(cyc);
      va_q.push_back(sa);
      vb_q.push_back(sb);
    end
    if (cs === 1'b0) cs_len++;
    else if (cs_len != 0) begin
      cl_q.push_back(cs_len);
      cs_len = 0;
    end
    if (svalid2 === 1'b1) begin
      vc2_q.push_back(cyc);
      va2_q.push_back(sa2);
      vb2_q.push_back(sb2);
    end
  end

  task automatic wait_valid(input int n, input int limit);
    for (int i = 0; i < limit && vc_q.size() < n; i++) @(negedge clk);
    if (vc_q.size() < n) chk("timeout_valid", 32'(vc_q.size()), 32'(n));
  endtask

  task automatic wait_bit(input int b, input int limit);
    int i;
    for (i = 0; i < limit && !(cs === 1'b0 && m_bit == b); i++) @(negedge clk);
    if (i >= limit) chk("timeout_bit", 32'(m_bit), 32'(b));
  endtask

  initial begin
    for (int k = 0; k < 14; k++) begin
      w2a[k] = 14'h2000 >> k;
      w2b[k] = 14'h0001 << k;
    end

    // Reset state.
    @(negedge clk);
    chk("rst_cs",      32'(cs), 32'd1);
    chk("rst_sck",     32'(sck), 32'd1);
    chk("rst_rd_done", 32'(rd_done), 32'd0);
    chk("rst_sa",      32'(sa), 32'd0);
    chk("rst_sb",      32'(sb), 32'd0);
    chk("rst_valid",   32'(svalid), 32'd0);

    // Release with en high: CS falls on the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    chk("cs_pre_fall", 32'(cs), 32'd1);
    @(negedge clk);
    chk("cs_fall",     32'(cs), 32'd0);
    chk("rd_done_low", 32'(rd_done), 32'd0);

    // First frame.
    wait_valid(1, 300);
    @(negedge clk);
    chk("f0_rd_done", 32'(rd_done), 32'd1);
    chk("f0_cs_high", 32'(cs), 32'd1);

    // Three more back-to-back frames with en held.
    wait_valid(4, 600);
    for (int k = 0; k < 4 && k < vc_q.size(); k++) begin
      chk($sformatf("word_a%0d", k), 32'(va_q[k]), 32'(fa[k]));
      chk($sformatf("word_b%0d", k), 32'(vb_q[k]), 32'(fb[k]));
    end
    for (int k = 1; k < 4 && k < vc_q.size(); k++)
      chk($sformatf("period%0d", k), 32'(vc_q[k] - vc_q[k-1]), 32'd125);
    for (int k = 0; k < 4 && k < cl_q.size(); k++)
      chk($sformatf("cs_low%0d", k), 32'(cl_q[k]), 32'd116);
    chk("cs_low_count", 32'(cl_q.size() >= 4), 32'd1);

    // Drop en at bit 6 of the next frame: it completes, then the block parks.
    wait_bit(6, 400);
    en = 1'b0;
    wait_valid(5, 300);
    if (vc_q.size() >= 5) begin
      chk("endrop_a", 32'(va_q[4]), 32'h0C3A);
      chk("endrop_b", 32'(vb_q[4]), 32'h3001);
    end
    repeat (300) @(negedge clk);
    chk("park_no_frame", 32'(vc_q.size()), 32'd5);
    chk("park_cs",       32'(cs), 32'd1);
    chk("park_rd_done",  32'(rd_done), 32'd1);
    chk("park_sa_hold",  32'(sa), 32'h0C3A);

    // Restart, then reset during bit 9: outputs clear asynchronously.
    en = 1'b1;
    wait_bit(9, 200);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs",      32'(cs), 32'd1);
    chk("mid_rst_sck",     32'(sck), 32'd1);
    chk("mid_rst_rd_done", 32'(rd_done), 32'd0);
    chk("mid_rst_sa",      32'(sa), 32'd0);
    chk("mid_rst_sb",      32'(sb), 32'd0);
    chk("mid_rst_valid",   32'(svalid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_no_valid", 32'(vc_q.size()), 32'd5);
    wait_valid(6, 300);
    if (vc_q.size() >= 6) begin
      chk("post_rst_a", 32'(va_q[5]), 32'h1ABC);
      chk("post_rst_b", 32'(vb_q[5]), 32'h0DEF);
    end
    en = 1'b0;

    // Fast instance: walking single-bit words, 60-cycle frame period.
    @(negedge clk);
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int i = 0; i < 1000 && vc2_q.size() < 14; i++) @(negedge clk);
    chk("fast_frames", 32'(vc2_q.size() >= 14), 32'd1);
    for (int k = 0; k < 14 && k < vc2_q.size(); k++) begin
      chk($sformatf("walk_a%0d", k), 32'(va2_q[k]), 32'(w2a[k]));
      chk($sformatf("walk_b%0d", k), 32'(vb2_q[k]), 32'(w2b[k]));
    end
    for (int k = 1; k < 14 && k < vc2_q.size(); k++)
      chk($sformatf("fast_period%0d", k), 32'(vc2_q[k] - vc2_q[k-1]), 32'd60);
    en2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_dual_serial_rx.md
# adc_dual_serial_rx

Dual-channel serial ADC reader that drives the converter's CS, SCK and RD_DONE lines and deserialises the two data lines DOUTA/DOUTB into 14-bit parallel samples. It sits directly downstream of the ADC, or of the on-chip ADC stimulus generator, and feeds the low-pass filter input. One frame yields one sample per channel, with a single-cycle valid strobe.

## Interface
- CLK_DIV, 4: clk cycles per SCK half-period; legal range ≥ 2.
- CONV_GAP, 8: clk cycles CS stays high after the DONE cycle before the next frame; legal range ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable, sampled only in IDLE and at the end of GAP.
- DOUTA  in  1  serial data, channel A, MSB first.
- DOUTB  in  1  serial data, channel B, MSB first.
- CS  out  1  converter chip select, active low.
- SCK  out  1  serial clock; idles high.
- RD_DONE  out  1  frame-read-complete flag to the converter.
- sample_a  out  14  last captured channel-A word.
- sample_b  out  14  last captured channel-B word.
- sample_valid  out  1  one-cycle pulse when sample_a/b update.

## Operation
- All outputs are registered.
- Reset values: CS=1, SCK=1, RD_DONE=0, sample_a=0, sample_b=0, sample_valid=0, state=IDLE, bit counter=13.
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: CS=1, SCK=1. If en=1, go to SETUP; CS=0 and RD_DONE=0 from the next cycle.
- SETUP: CS=0, SCK=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 14 SCK periods. Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - On the edge where SCK goes 0→1, shift DOUTA/DOUTB into the channel shift registers (left shift, new bit in LSB) and decrement the bit counter 13→0.
  - After the high half of the 14th period ends, go to DONE.
- DONE (1 cycle): CS=1, RD_DONE=1, sample_valid=1. sample_a/b are loaded from the shift registers on the edge entering DONE. Bit counter reloads to 13.
- GAP: CS=1, SCK=1, RD_DONE held at 1, CONV_GAP cycles. At the end, go to SETUP if en=1, otherwise IDLE. RD_DONE clears when CS next falls.
- en deasserted in SETUP or SHIFT does not abort the frame; the frame completes and the block then parks in IDLE.
- Data is captured as delivered. Upper bits carry whatever the converter sends (zeros from the 8-bit stimulus generator). No sign conversion.

## Timing
- CS low time: 29·CLK_DIV cycles (116 at default).
- Frame period with en held high: 29·CLK_DIV + 1 + CONV_GAP (125 at default).
- Bit k (13=MSB) is sampled at the end of its low half, giving the converter CLK_DIV cycles of settling after the falling edge.
- Latency from the last SCK rising edge to sample_valid: 1 cycle after the end of that high half. Equivalently, valid asserts CLK_DIV+1 cycles after the 14th capture-trigger rising edge.
- sample_a/b hold their value between frames; they change only together with sample_valid.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The partial word is discarded, no valid pulse is issued, and a fresh frame starts via IDLE.
- No metastability synchroniser on DOUTx: SCK is generated locally and data is stable for the full low half-period.

## Structure
- Shared package holds: NBITS=14, the state encoding (IDLE/SETUP/SHIFT/DONE/GAP), and the default CLK_DIV/CONV_GAP constants.
- Sub-module adc_sck_tick: a CLK_DIV down-counter producing a half-period tick and an SCK phase toggle, enabled only in SETUP/SHIFT. The FSM, bit counter and shift registers stay in the top level.

## Test plan
- Reset release with en=1, serial model returning A=0x2A5B, B=0x1234 -> CS falls 1 cycle after reset release; sample_valid pulses once; sample_a=0x2A5B, sample_b=0x1234.
- en held high for 3 frames with words 0x0000 / 0x3FFF / 0x2AAA -> valid pulses exactly 125 cycles apart; each word captured exactly; CS low for exactly 116 cycles per frame.
- en dropped at bit 6 of frame 2 -> frame 2 completes with a correct word and a valid pulse; CS stays high afterwards; no third frame.
- rst pulsed during bit 9 -> CS=1, SCK=1, RD_DONE=0 and samples=0 the same cycle; no valid pulse; the next frame captures a clean word.
- CLK_DIV=2, CONV_GAP=1 -> frame period 60 cycles; single-bit-set walking patterns 0x2000..0x0001 on both channels captured correctly.
